// File: rtl/pwm_irq_controller.sv
// Interrupt receiver for the PWM carriers: rising-edge capture into sticky pending bits,
// enable masking, one registered level IRQ with source id, and an ack hold-off timer.
module pwm_irq_controller #(
    parameter  int PWM_WIDTH   = 8,
    parameter  int HOLDOFF_CYC = 16,
    parameter  int CNT_WIDTH   = 16,
    localparam int ID_W        = (PWM_WIDTH > 1) ? $clog2(PWM_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PWM_WIDTH-1:0] interrupt_in,
    input  logic [PWM_WIDTH-1:0] matrix,
    input  logic                 clr_valid,
    input  logic [PWM_WIDTH-1:0] clr_mask,
    input  logic                 irq_ack,
    output logic                 irq,
    output logic [ID_W-1:0]      irq_id,
    output logic [PWM_WIDTH-1:0] pending,
    output logic [PWM_WIDTH-1:0] overrun,
    output logic [CNT_WIDTH-1:0] irq_count,
    output logic [1:0]           state_dbg
);

    localparam int HCNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam logic [HCNT_W-1:0] HCNT_LOAD =
        (HOLDOFF_CYC > 0) ? HCNT_W'(HOLDOFF_CYC - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PWM_WIDTH-1:0]   in_q, in_d;
    logic [PWM_WIDTH-1:0]   pending_q, pending_d;
    logic [PWM_WIDTH-1:0]   overrun_q, overrun_d;
    logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
    logic                   irq_q, irq_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [PWM_WIDTH-1:0]   evt;
    logic [PWM_WIDTH-1:0]   clr;
    logic [PWM_WIDTH-1:0]   active;
    logic [ID_W-1:0]        low_idx;

    // clr_valid and irq_ack are single-cycle qualifiers with no ready side: a strobe
    // is consumed on the clock edge where it is high, and irq_ack counts only in ASSERT.
    always_comb begin
        in_d      = interrupt_in;
        evt       = interrupt_in & ~in_q;
        clr       = clr_valid ? clr_mask : '0;
        pending_d = evt | (pending_q & ~clr);
        overrun_d = (evt & pending_q) | (overrun_q & ~clr);
        active    = pending_q & matrix;
    end

    always_comb begin
        low_idx = '0;
        for (int i = PWM_WIDTH - 1; i >= 0; i--) begin
            if (active[i]) low_idx = ID_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = ASSERT;
                    id_d    = low_idx;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    if (HOLDOFF_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        hcnt_d  = HCNT_LOAD;
                    end
                end else if (!(|active)) begin
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                // The IDLE cycle that follows completes the low interval, so leave one early.
                if (hcnt_q <= HCNT_W'(1)) state_d = IDLE;
                else                      hcnt_d  = hcnt_q - HCNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == ASSERT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            in_q      <= '1;
            pending_q <= '0;
            overrun_q <= '0;
            hcnt_q    <= '0;
            irq_q     <= 1'b0;
            id_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_q      <= in_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            hcnt_q    <= hcnt_d;
            irq_q     <= irq_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
        end
    end

    assign irq       = irq_q;
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;
    assign irq_count = cnt_q;
    assign state_dbg = state_q;

endmodule
